// File: rtl/pool_window_ctrl.sv
// pool_window_ctrl: streaming K x K, stride-K max pooling over one feature map
// per start pulse. One partial-max accumulator per output column; pooled
// pixels leave row-major on a valid/ready port.
// Optional build macro: POOL_STALL_CNT_EN adds a 16-bit saturating stall_cnt
// output counting cycles with out_valid && !out_ready.
module pool_window_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pix,
  output logic              out_last
`ifdef POOL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int OW = IMG_W / POOL;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = $clog2(POOL);
  localparam int AW = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [PW-1:0]     wx_q, wx_d;
  logic [PW-1:0]     wy_q, wy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pix_q, out_pix_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W-1:0] acc_q [OW];
  logic [AW-1:0]     a_idx;
  logic [DATA_W-1:0] acc_rd;
  logic [DATA_W-1:0] pix_max;
  logic              accept;
  logic              out_fire;
  logic              win_first;
  logic              win_done;
  logic              last_beat;

  assign a_idx     = AW'(col_q / CW'(POOL));
  assign acc_rd    = acc_q[a_idx];
  // Ties keep the stored value; for a max the result is the same either way.
  assign pix_max   = (in_pix > acc_rd) ? in_pix : acc_rd;
  assign win_first = (wx_q == '0) && (wy_q == '0);
  assign win_done  = (wx_q == PW'(POOL-1)) && (wy_q == PW'(POOL-1));
  assign last_beat = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));

  // A new input is taken only when the single output slot is free or draining now.
  assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign out_valid  = out_valid_q;
  assign out_pix    = out_pix_q;
  assign out_last   = out_last_q;

  // Next-state: FSM, window counters and the registered output slot.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    out_valid_d  = out_valid_q;
    out_pix_d    = out_pix_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
          wx_d    = '0;
          wy_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          wx_d = (wx_q == PW'(POOL-1)) ? '0 : wx_q + 1'b1;
          if (col_q == CW'(IMG_W-1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
            wy_d  = (wy_q == PW'(POOL-1)) ? '0 : wy_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          // Completing beat refills the slot, overriding a same-cycle drain.
          if (win_done) begin
            out_valid_d = 1'b1;
            out_pix_d   = pix_max;
            out_last_d  = last_beat;
            if (last_beat) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      out_valid_q  <= 1'b0;
      out_pix_q    <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      out_valid_q  <= out_valid_d;
      out_pix_q    <= out_pix_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Per-column partial max; first beat of a window overwrites, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) acc_q[a_idx] <= win_first ? in_pix : pix_max;
  end

`ifdef POOL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Stall count: cleared by an accepted start, saturating, held after the frame.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start)                           stall_d = '0;
    else if (out_valid_q && !out_ready && stall_q != '1)    stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
